update_knn12_topk_sel: RTL

- Downstream consumer of the update_knn12 distance multiplier (unsigned 17x15 -> 32-bit product, 2-cycle latency, ce-gated).
- Receives a stream of 32-bit distances, each tagged with a training label.
- Keeps the K smallest distances in ascending order in a register array.
- After the stream's last sample, presents the sorted K-nearest set to the vote stage through a valid/ready handshake.

---
 rtl/update_knn12_topk_sel_if.sv | 29 ++
 rtl/update_knn12_topk_sel.sv | 126 ++++++++++++
 2 files changed

// File: rtl/update_knn12_topk_sel_if.sv
// Sample stream in, sorted K-nearest result out, for the update_knn12 top-K selector.
interface update_knn12_topk_sel_if #(
    parameter int K      = 3,
    parameter int DIST_W = 32,
    parameter int LBL_W  = 8,
    parameter int CNT_W  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIST_W-1:0]     in_dist;
    logic [LBL_W-1:0]      in_label;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [K*DIST_W-1:0]   out_dist;
    logic [K*LBL_W-1:0]    out_label;
    logic [CNT_W-1:0]      out_count;

    // Upstream producer and downstream vote stage, seen together from outside the block
    modport master (
        output in_valid, in_dist, in_label, in_last, out_ready,
        input  in_ready, out_valid, out_dist, out_label, out_count
    );

    modport slave (
        input  in_valid, in_dist, in_label, in_last, out_ready,
        output in_ready, out_valid, out_dist, out_label, out_count
    );
endinterface

// File: rtl/update_knn12_topk_sel.sv
// Keeps the K smallest (distance, label) pairs of a query in ascending order and
// hands the sorted set to the vote stage once the query's last sample arrives.
module update_knn12_topk_sel #(
    parameter int K      = 3,
    parameter int DIST_W = 32,
    parameter int LBL_W  = 8,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    update_knn12_topk_sel_if.slave bus
);

    typedef enum logic {
        ACC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DIST_W-1:0] dist_q [K];
    logic [DIST_W-1:0] dist_d [K];
    logic [LBL_W-1:0]  lbl_q  [K];
    logic [LBL_W-1:0]  lbl_d  [K];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [K-1:0]      lt;
    logic [K-1:0]      lt_prev;
    logic              ready;
    logic              accept;
    logic              handshake;

    // reset is folded in so in_ready stays low for the whole time reset is held
    assign ready     = ce && reset && (state_q == ACC);
    assign accept    = bus.in_valid && ready;
    assign handshake = (state_q == DONE) && bus.out_ready && ce;

    // Slots stay sorted, so lt is a thermometer: the first set bit is the insert point
    always_comb begin
        lt = '0;
        for (int i = 0; i < K; i++) begin
            lt[i] = (bus.in_dist < dist_q[i]);
        end
    end

    assign lt_prev = lt << 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACC;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (accept && bus.in_last) state_d = DONE;
            DONE:    if (handshake)             state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // Slot i takes slot i-1 when the new sample lands below it, or the new sample itself
    // when i is the insert point; slot K-1's old content simply falls off the end.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            dist_d[i] = dist_q[i];
            lbl_d[i]  = lbl_q[i];
        end
        cnt_d = cnt_q;

        if (accept) begin
            if (lt[0]) begin
                dist_d[0] = bus.in_dist;
                lbl_d[0]  = bus.in_label;
            end
            for (int i = 1; i < K; i++) begin
                if (lt_prev[i]) begin
                    dist_d[i] = dist_q[i-1];
                    lbl_d[i]  = lbl_q[i-1];
                end else if (lt[i]) begin
                    dist_d[i] = bus.in_dist;
                    lbl_d[i]  = bus.in_label;
                end
            end
            if (cnt_q != CNT_W'(K)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (handshake) begin
            for (int i = 0; i < K; i++) begin
                dist_d[i] = '1;
                lbl_d[i]  = '0;
            end
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= '1;
                lbl_q[i]  <= '0;
            end
            cnt_q <= '0;
        end else if (ce) begin
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= dist_d[i];
                lbl_q[i]  <= lbl_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_count = cnt_q;

    for (genvar g = 0; g < K; g++) begin : g_out
        assign bus.out_dist[g*DIST_W +: DIST_W] = dist_q[g];
        assign bus.out_label[g*LBL_W +: LBL_W]  = lbl_q[g];
    end

endmodule
